wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
Pipelined Wishbone bus master. It converts single-shot commands from local control logic into one Wishbone transaction each, such as starting an LED sweep by writing address 0, or polling a peripheral's status by read. It honours slave stall, waits for ack, enforces a timeout, and returns one response per command. It sits between firmware-less control FSMs and Wishbone slave peripherals on the same clock.

Parameters:
AW, 16, address width.
DW, 16, data width; narrower slave read data is zero-extended by the interconnect.
TIMEOUT, 200, maximum cycles from o_wb_stb assertion to ack before the transaction is aborted; legal range 2..255.

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_cmd_stb  in  1  command request; sampled only when o_cmd_busy=0.
i_cmd_we  in  1  1=write, 0=read.
i_cmd_addr  in  AW  transaction address.
i_cmd_data  in  DW  write data; ignored for reads.
o_cmd_busy  out  1  transaction in progress; commands are ignored, not queued.
o_rsp_stb  out  1  one-cycle pulse, one per accepted command.
o_rsp_data  out  DW  read data captured on ack; 0 for writes and errors.
o_rsp_err  out  1  qualified by o_rsp_stb; 1 = timeout.
o_wb_cyc  out  1  bus cycle.
o_wb_stb  out  1  request strobe.
o_wb_we  out  1  write enable.
o_wb_addr  out  AW  address.
o_wb_data  out  DW  write data.
i_wb_stall  in  1  slave stall.
i_wb_ack  in  1  slave acknowledge.
i_wb_data  in  DW  slave read data.

Behaviour:
- One clock i_clk. Reset i_reset_n is asynchronous and active-low.
- During reset: state IDLE. All outputs are 0, including o_wb_addr, o_wb_data and o_rsp_data. The timeout counter is 0.
- All outputs are registered except o_cmd_busy, which equals (state != IDLE) decoded from the state register.
- States: IDLE, REQ, WAIT_ACK.
- IDLE: if i_cmd_stb, latch we/addr/data onto o_wb_we/o_wb_addr/o_wb_data, set o_wb_cyc=o_wb_stb=1, clear the counter, and go to REQ.
- REQ: o_wb_stb=1, o_wb_cyc=1. When i_wb_stall=0, the request is accepted this edge. On acceptance, o_wb_stb drops next cycle and the state goes to WAIT_ACK. While stalled, we/addr/data are held stable.
- WAIT_ACK: o_wb_cyc=1, o_wb_stb=0. On i_wb_ack, do the following next edge:
  - capture i_wb_data into o_rsp_data for reads, or 0 for writes;
  - pulse o_rsp_stb with o_rsp_err=0;
  - drop o_wb_cyc and return to IDLE.
- An ack sampled in REQ, or in the same cycle as acceptance, has no request outstanding. It is ignored and does not complete the transaction.
- The timeout counter increments every cycle in REQ and WAIT_ACK. When it equals TIMEOUT-1 with no ack that cycle, do the following next edge:
  - drop o_wb_cyc and o_wb_stb;
  - pulse o_rsp_stb with o_rsp_err=1 and o_rsp_data=0;
  - return to IDLE.
- If ack and timeout occur in the same cycle, ack wins and the response is a normal completion.
- Invariants:
  - o_wb_stb implies o_wb_cyc.
  - o_wb_cyc rises together with o_wb_stb.
  - At most one request is outstanding.
  - o_rsp_stb is never high for two consecutive cycles.
- Back-to-back: in the cycle o_rsp_stb is high the state is IDLE. A new command presented that cycle is accepted, and o_wb_cyc re-asserts the following cycle, leaving one idle cycle with cyc low.
- Latency with no stall and the ack one cycle after acceptance:
  - command accepted at edge N;
  - stb high in cycle N+1;
  - ack sampled at N+2;
  - o_rsp_stb in cycle N+3; 3 cycles total.
- Each stall cycle adds one cycle.
- Reset asserted mid-transaction: outputs clear immediately, no response is issued, and the pending command is lost.

Test Plan:
- Write 0x0000 to addr 0x0000, no stall, ack next cycle:
  - o_wb_stb high exactly 1 cycle with we=1, addr=0;
  - o_rsp_stb exactly 3 cycles after acceptance, err=0, data=0.
- Read addr 0x0001, stall held 3 cycles, slave returns 0x000F:
  - stb high 4 cycles with addr/we stable;
  - o_rsp_data=0x000F, err=0, latency 6 cycles.
- No ack ever, TIMEOUT=200:
  - o_wb_cyc drops exactly 200 cycles after stb assertion;
  - o_rsp_stb with err=1, data=0; o_cmd_busy low the same cycle.
- Ack arrives exactly on the timeout cycle: normal completion, err=0, data captured.
- i_cmd_stb held high continuously for writes, slave always ready: one transaction every 4 cycles, one rsp pulse per transaction, cmd data changes while busy are ignored.
- i_reset_n pulsed low during WAIT_ACK:
  - all outputs 0 asynchronously and no o_rsp_stb;
  - next command after release completes normally.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-shot command to pipelined Wishbone master.
// Each accepted command becomes exactly one bus transaction and one response
// pulse; a transaction that is not acknowledged in time is aborted with err=1.
module wb_cmd_master #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 200   // 2..255, cycles from stb assertion to abort
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  // local command side
  input  logic          i_cmd_stb,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_data,
  output logic          o_cmd_busy,
  output logic          o_rsp_stb,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_err,
  // Wishbone master side
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            rsp_stb_q, rsp_stb_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  // Counter value seen on the last cycle before the transaction is abandoned.
  logic            timeout_hit;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    rsp_stb_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (i_cmd_stb) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdat_d  = i_cmd_data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        // Nothing is outstanding yet, so any ack seen here is ignored.
        cnt_d = cnt_q + 8'd1;
        if (timeout_hit) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = IDLE;
        end else if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        cnt_d = cnt_q + 8'd1;
        // Ack takes priority over a timeout landing on the same cycle.
        if (i_wb_ack) begin
          cyc_d      = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_data_d = we_q ? '0 : i_wb_data;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus and discards any pending command.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rsp_stb_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_cmd_busy = (state_q != IDLE);
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = wdat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: cycle-timestamp transaction model, scripted slave,
// directed scenarios with hand-computed latencies and data.
module tb_wb_cmd_master;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 200;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_cmd_stb = 1'b0;
  logic          i_cmd_we = 1'b0;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [DW-1:0] i_cmd_data = '0;
  logic          o_cmd_busy, o_rsp_stb, o_rsp_err;
  logic [DW-1:0] o_rsp_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_ack = 1'b0;
  logic [DW-1:0] i_wb_data = '0;

  always #5 i_clk = ~i_clk;

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_stb(i_cmd_stb), .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
    .i_cmd_data(i_cmd_data), .o_cmd_busy(o_cmd_busy),
    .o_rsp_stb(o_rsp_stb), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // Works on absolute edge numbers: a transaction starts at edge s, its request
  // is taken at the first edge with stall low, the first ack sampled after that
  // edge completes it, and it is abandoned at edge s+TO if nothing completed it.
  int            cyc_n = 0;
  bit            m_busy = 0, m_pend = 0;
  int            m_start = 0;
  logic          e_cyc = 0, e_stb = 0, e_we = 0, e_rsp_stb = 0, e_rsp_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0, e_rsp_data = '0;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_busy = 0; m_pend = 0;
      e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_data = '0;
      e_rsp_stb = 0; e_rsp_err = 0; e_rsp_data = '0;
    end else begin
      cyc_n++;
      e_rsp_stb = 0;
      if (!m_busy) begin
        if (i_cmd_stb) begin
          m_busy = 1; m_pend = 1; m_start = cyc_n;
          e_cyc = 1; e_stb = 1;
          e_we = i_cmd_we; e_addr = i_cmd_addr; e_data = i_cmd_data;
        end
      end else if (!m_pend && i_wb_ack) begin
        m_busy = 0; e_cyc = 0; e_stb = 0;
        e_rsp_stb = 1; e_rsp_err = 0;
        e_rsp_data = e_we ? '0 : i_wb_data;
      end else if (cyc_n - m_start == TO) begin
        m_busy = 0; m_pend = 0; e_cyc = 0; e_stb = 0;
        e_rsp_stb = 1; e_rsp_err = 1; e_rsp_data = '0;
      end else if (m_pend && !i_wb_stall) begin
        m_pend = 0; e_stb = 0;
      end
    end
  end

  // Compare every output against the model, plus the bus invariants.
  logic prev_rsp = 0;
  always @(negedge i_clk) begin
    check("cyc",      o_wb_cyc,   e_cyc);
    check("stb",      o_wb_stb,   e_stb);
    check("we",       o_wb_we,    e_we);
    check("addr",     o_wb_addr,  e_addr);
    check("wdata",    o_wb_data,  e_data);
    check("busy",     o_cmd_busy, m_busy);
    check("rsp_stb",  o_rsp_stb,  e_rsp_stb);
    check("rsp_err",  o_rsp_err,  e_rsp_err);
    check("rsp_data", o_rsp_data, e_rsp_data);
    check("stb_without_cyc", o_wb_stb & ~o_wb_cyc, 1'b0);
    check("rsp_back_to_back", o_rsp_stb & prev_rsp, 1'b0);
    prev_rsp = o_rsp_stb;
  end

  // ---------------- scripted slave ----------------
  // stall_left: stalled request cycles still to serve; ack_dly: edges after
  // acceptance at which ack is sampled (0 = never); spur_en: also ack while stb high.
  int            stall_left = 0;
  int            ack_dly = 1;
  int            ack_wait = 0;
  bit            spur_en = 0;
  logic [DW-1:0] slv_data = '0;

  always @(posedge i_clk) begin
    if (o_wb_stb && !i_wb_stall) ack_wait = ack_dly;
    else if (ack_wait > 0)       ack_wait--;
    if (o_wb_stb && i_wb_stall && stall_left > 0) stall_left--;
    #1;
    i_wb_stall = (stall_left > 0);
    i_wb_ack   = (ack_wait == 1) || (spur_en && o_wb_stb);
    i_wb_data  = slv_data;
  end

  // ---------------- observation ----------------
  int            stb_cnt = 0, rsp_total = 0, rsp_at = 0, rsp_prev_at = 0;
  bit            rsp_seen = 0, stb_unstable = 0, prev_stb = 0;
  logic          stb_we = 0, rsp_e = 0, cyc_at_rsp = 0, busy_at_rsp = 0, prev_we = 0;
  logic [AW-1:0] stb_addr = '0, prev_addr = '0;
  logic [DW-1:0] rsp_d = '0, prev_wd = '0;

  always @(negedge i_clk) begin
    if (o_wb_stb) begin
      stb_cnt++;
      if (prev_stb && (o_wb_addr !== prev_addr || o_wb_we !== prev_we || o_wb_data !== prev_wd))
        stb_unstable = 1;
      stb_addr = o_wb_addr; stb_we = o_wb_we;
    end
    prev_stb = o_wb_stb; prev_addr = o_wb_addr; prev_we = o_wb_we; prev_wd = o_wb_data;
    if (o_rsp_stb) begin
      rsp_seen = 1; rsp_total++;
      rsp_prev_at = rsp_at; rsp_at = cyc_n;
      rsp_d = o_rsp_data; rsp_e = o_rsp_err;
      cyc_at_rsp = o_wb_cyc; busy_at_rsp = o_cmd_busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Present a command for one edge; s returns the edge number it was taken on.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int s);
    @(posedge i_clk); #1;
    stb_cnt = 0; stb_unstable = 0; rsp_seen = 0;
    i_cmd_stb = 1; i_cmd_we = we; i_cmd_addr = a; i_cmd_data = d;
    @(posedge i_clk); #1;
    s = cyc_n;
    i_cmd_stb = 0;
  endtask

  task automatic wait_rsp(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      @(negedge i_clk); #1;
      if (rsp_seen) return;
    end
    check("rsp_wait_expired", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_cyc", o_wb_cyc, 1'b0);
    check("reset_stb", o_wb_stb, 1'b0);
    check("reset_busy", o_cmd_busy, 1'b0);
    check("reset_rsp_stb", o_rsp_stb, 1'b0);
    check("reset_rsp_data", o_rsp_data, 16'h0);
    i_reset_n = 1;
    idle(2);

    // 1: write 0x0000 @ 0x0000, no stall, ack one edge after acceptance
    ack_dly = 1; stall_left = 0; idle(1);
    issue(1'b1, 16'h0000, 16'h0000, s);
    wait_rsp(20);
    check("wr_stb_cycles", stb_cnt, 1);
    check("wr_stb_we", stb_we, 1'b1);
    check("wr_stb_addr", stb_addr, 16'h0000);
    check("wr_latency", rsp_at - s + 1, 3);
    check("wr_err", rsp_e, 1'b0);
    check("wr_data", rsp_d, 16'h0000);
    idle(2);

    // 2: read 0x0001, three stalled cycles, slave returns 0x000F
    stall_left = 3; slv_data = 16'h000F; idle(1);
    issue(1'b0, 16'h0001, 16'hDEAD, s);
    wait_rsp(20);
    check("rd_stb_cycles", stb_cnt, 4);
    check("rd_stb_stable", stb_unstable, 1'b0);
    check("rd_stb_addr", stb_addr, 16'h0001);
    check("rd_stb_we", stb_we, 1'b0);
    check("rd_latency", rsp_at - s + 1, 6);
    check("rd_data", rsp_d, 16'h000F);
    check("rd_err", rsp_e, 1'b0);
    idle(2);

    // 3: ack raised while the request is still stalled and on the acceptance
    //    cycle must not complete; the real ack one edge later does
    stall_left = 2; spur_en = 1; slv_data = 16'h1234; idle(1);
    issue(1'b0, 16'h0002, 16'h0000, s);
    wait_rsp(20);
    check("spur_latency", rsp_at - s + 1, 5);
    check("spur_data", rsp_d, 16'h1234);
    spur_en = 0; idle(2);

    // 4: no ack ever -> abort 200 edges after stb assertion
    ack_dly = 0; idle(1);
    issue(1'b1, 16'h0003, 16'h0005, s);
    wait_rsp(300);
    check("to_cyc_drop_edge", rsp_at - s, TO);
    check("to_err", rsp_e, 1'b1);
    check("to_data", rsp_d, 16'h0000);
    check("to_cyc_at_rsp", cyc_at_rsp, 1'b0);
    check("to_busy_at_rsp", busy_at_rsp, 1'b0);
    idle(2);

    // 5: ack sampled exactly on the timeout edge -> normal completion
    ack_dly = TO - 1; slv_data = 16'hBEEF; idle(1);
    issue(1'b0, 16'h0004, 16'h0000, s);
    wait_rsp(300);
    check("tie_edge", rsp_at - s, TO);
    check("tie_err", rsp_e, 1'b0);
    check("tie_data", rsp_d, 16'hBEEF);
    idle(2);

    // 6: cmd_stb held for writes; slave answers two edges after accepting
    ack_dly = 2; idle(1);
    s = rsp_total;
    @(posedge i_clk); #1;
    i_cmd_stb = 1; i_cmd_we = 1;
    for (int k = 0; k < 16; k++) begin
      i_cmd_addr = 16'h0100 + 16'(k);
      i_cmd_data = 16'hA000 + 16'(k);
      @(posedge i_clk); #1;
    end
    i_cmd_stb = 0;
    idle(6);
    check("stream_rsp_count", rsp_total - s, 4);
    check("stream_spacing", rsp_at - rsp_prev_at, 4);
    idle(2);

    // 7: reset mid WAIT_ACK: outputs clear at once, no response, then recover
    ack_dly = 0; idle(1);
    issue(1'b1, 16'h0007, 16'h0009, s);
    repeat (4) @(negedge i_clk);
    #2;
    check("pre_rst_cyc", o_wb_cyc, 1'b1);
    i_reset_n = 0;
    #1;
    check("rst_cyc", o_wb_cyc, 1'b0);
    check("rst_stb", o_wb_stb, 1'b0);
    check("rst_we", o_wb_we, 1'b0);
    check("rst_addr", o_wb_addr, 16'h0000);
    check("rst_wdata", o_wb_data, 16'h0000);
    check("rst_busy", o_cmd_busy, 1'b0);
    check("rst_rsp_data", o_rsp_data, 16'h0000);
    rsp_seen = 0;
    idle(3);
    #2 i_reset_n = 1;
    ack_dly = 1;
    idle(3);
    check("rst_no_rsp", rsp_seen, 1'b0);
    issue(1'b1, 16'h0008, 16'h0055, s);
    wait_rsp(20);
    check("post_rst_latency", rsp_at - s + 1, 3);
    check("post_rst_err", rsp_e, 1'b0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
